// File: rtl/sdram_line_packer.sv
// Packs an incoming byte stream into 128-bit lines and hands each line to the
// SDRAM controller over a req/ack handshake, with one line of buffering in flight.
module sdram_line_packer #(
  parameter int unsigned ADDR_STEP = 8,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic         iclk,
  input  logic         ireset_n,
  input  logic         ibyte_valid,
  input  logic [7:0]   ibyte,
  input  logic         iframe_end,
  input  logic         iaddr_load,
  input  logic [21:0]  istart_address,
  output logic         owrite_req,
  output logic [21:0]  owrite_address,
  output logic [127:0] owrite_data,
  input  logic         iwrite_ack,
  output logic         obusy,
  output logic         ooverflow,
  output logic [15:0]  oline_count,
  output logic         oframe_done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   asm_q, asm_d;
  logic [4:0]     byte_cnt_q, byte_cnt_d;
  logic [127:0]   pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic [21:0]    addr_q, addr_d;
  logic [15:0]    line_cnt_q, line_cnt_d;
  logic           ovf_q, ovf_d;
  logic           flush_q, flush_d;
  logic           frame_done_q, frame_done_d;

  logic [127:0]   asm_eff;
  logic [4:0]     cnt_eff;
  logic           pend_free;
  logic           line_move;
  logic           done_cond;
  logic           busy;

  function automatic logic [127:0] insert_byte(input logic [127:0] line,
                                               input logic [3:0]   idx,
                                               input logic [7:0]   b);
    logic [127:0] r;
    r = line;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Bytes at and above position cnt become PAD_BYTE.
  function automatic logic [127:0] pad_line(input logic [127:0] line,
                                            input logic [4:0]   cnt);
    logic [127:0] r;
    r = line;
    for (int k = 0; k < 16; k++) begin
      if (5'(k) >= cnt) r[8*k +: 8] = PAD_BYTE;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (pend_vld_q)  state_d = S_REQ;
      S_REQ:      if (iwrite_ack)  state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!iwrite_ack) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    owrite_req = (state_q == S_REQ);
    busy       = (byte_cnt_q != 5'd0) | pend_vld_q | (state_q != S_IDLE);
  end

  // A byte arriving with iframe_end is packed before the flush pads the line;
  // a full line held because pending is occupied (cnt==16) rejects new bytes.
  always_comb begin
    asm_eff = asm_q;
    cnt_eff = byte_cnt_q;
    ovf_d   = ovf_q;
    if (ibyte_valid) begin
      if (byte_cnt_q == 5'd16) begin
        ovf_d = 1'b1;
      end else begin
        asm_eff = insert_byte(asm_q, byte_cnt_q[3:0], ibyte);
        cnt_eff = byte_cnt_q + 5'd1;
      end
    end
    if (iframe_end && (cnt_eff != 5'd0) && (cnt_eff != 5'd16)) begin
      asm_eff = pad_line(asm_eff, cnt_eff);
      cnt_eff = 5'd16;
    end

    pend_free = (state_q == S_REQ) && iwrite_ack;
    line_move = (cnt_eff == 5'd16) && (!pend_vld_q || pend_free);

    asm_d      = asm_eff;
    byte_cnt_d = cnt_eff;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q & ~pend_free;
    if (line_move) begin
      asm_d      = '0;
      byte_cnt_d = 5'd0;
      pend_d     = asm_eff;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    addr_d     = addr_q;
    line_cnt_d = line_cnt_q;
    if (pend_free) begin
      addr_d     = addr_q + 22'(ADDR_STEP);
      line_cnt_d = line_cnt_q + 16'd1;
    end else if (iaddr_load && !busy) begin
      addr_d = istart_address;
    end
  end

  // A frame-end seen while the pulse fires starts a new frame rather than being lost.
  always_comb begin
    done_cond    = flush_q && (byte_cnt_q == 5'd0) && !pend_vld_q && (state_q == S_IDLE);
    frame_done_d = done_cond;
    flush_d      = iframe_end | (flush_q & ~done_cond);
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      asm_q        <= '0;
      byte_cnt_q   <= 5'd0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      addr_q       <= 22'd0;
      line_cnt_q   <= 16'd0;
      ovf_q        <= 1'b0;
      flush_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      byte_cnt_q   <= byte_cnt_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      addr_q       <= addr_d;
      line_cnt_q   <= line_cnt_d;
      ovf_q        <= ovf_d;
      flush_q      <= flush_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign owrite_address = addr_q;
  assign owrite_data    = pend_q;
  assign obusy          = busy;
  assign ooverflow      = ovf_q;
  assign oline_count    = line_cnt_q;
  assign oframe_done    = frame_done_q;

endmodule
